// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   bcd_state_t    : converter FSM states (idle / shifting / result-valid)
//   BCD_NIBBLE     : bits per BCD digit
//   BCD_ADJ_THRESH : digit value at or above which the pre-shift adjust applies
//   BCD_ADJ_ADD    : amount added by the pre-shift adjust
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} bcd_state_t;

  localparam int BCD_NIBBLE     = 4;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_ADD    = 3;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adjust.sv
// Double-dabble digit correction, purely combinational.
//   digit_i [3:0] : BCD digit before the shift (0-9 in normal operation)
//   digit_o [3:0] : digit_i + 3 when digit_i >= 5, otherwise digit_i
// Adding 3 before a left shift makes a digit >= 5 carry into the next
// digit after doubling, keeping every digit in 0-9.
module bcd_digit_adjust
  import bin_to_bcd_pkg::*;
(
  input  logic [BCD_NIBBLE-1:0] digit_i,
  output logic [BCD_NIBBLE-1:0] digit_o
);

  always_comb begin
    if (digit_i >= BCD_NIBBLE'(BCD_ADJ_THRESH)) begin
      digit_o = digit_i + BCD_NIBBLE'(BCD_ADJ_ADD);
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One bit of the operand is consumed per clock; a conversion takes WIDTH
// shift cycles plus one DONE cycle plus one IDLE cycle for the next start.
//   clk_i      : clock, all state changes on the rising edge
//   rst_ni     : synchronous active-low reset, aborts any conversion
//   start_i    : conversion request, accepted only while ready_o=1
//   bin_i      : unsigned operand, sampled on the accepting edge
//   ready_o    : high in IDLE
//   done_o     : one-cycle pulse when bcd_o/overflow_o hold a new result
//   bcd_o      : packed BCD result, digit 0 (units) in bits [3:0]
//   overflow_o : last operand was >= 10^DIGITS (bcd_o is then the value
//                modulo 10^DIGITS)
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [WIDTH-1:0]           bin_i,
  output logic                       ready_o,
  output logic                       done_o,
  output logic [BCD_NIBBLE*DIGITS-1:0] bcd_o,
  output logic                       overflow_o
);

  localparam int BCD_W = BCD_NIBBLE * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int CAT_W = BCD_W + WIDTH + 1;

  bcd_state_t         state_q, state_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [BCD_W-1:0]   w_q, w_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               overflow_q, overflow_d;

  // Adjusted working digits and the combined shift result.
  logic [BCD_W-1:0]   w_adj;
  logic [CAT_W-1:0]   shifted;
  logic               carry;
  logic [BCD_W-1:0]   w_shift;
  logic [WIDTH-1:0]   b_shift;
  logic               last_shift;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (w_q  [gi*BCD_NIBBLE +: BCD_NIBBLE]),
      .digit_o (w_adj[gi*BCD_NIBBLE +: BCD_NIBBLE])
    );
  end

  // {carry, W, B} << 1 expressed as one concatenation so it stays legal
  // for WIDTH=1 (no B[WIDTH-2:0] slice needed).
  always_comb begin
    shifted = {w_adj, b_q, 1'b0};
    carry   = shifted[CAT_W-1];
    w_shift = shifted[CAT_W-2:WIDTH];
    b_shift = shifted[WIDTH-1:0];
  end

  assign last_shift = (cnt_q == CNT_W'(1));

  // State register plus datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      b_q        <= '0;
      w_q        <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      w_q        <= w_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i)    state_d = S_SHIFT;
      S_SHIFT: if (last_shift) state_d = S_DONE;
      S_DONE:                  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    b_d        = b_q;
    w_d        = w_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          b_d   = bin_i;
          w_d   = '0;
          ovf_d = 1'b0;
          cnt_d = CNT_W'(WIDTH);
        end
      end
      S_SHIFT: begin
        b_d   = b_shift;
        w_d   = w_shift;
        ovf_d = ovf_q | carry;
        cnt_d = cnt_q - CNT_W'(1);
        // Commit on the final shift so the outputs never show partials.
        if (last_shift) begin
          bcd_d      = w_shift;
          overflow_d = ovf_q | carry;
        end
      end
      default: ;
    endcase
  end

  // Output decode: state-only, no path from the inputs.
  always_comb begin
    ready_o = (state_q == S_IDLE);
    done_o  = (state_q == S_DONE);
  end

  assign bcd_o      = bcd_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        start_a;
  logic [15:0] bin_a;
  logic        ready_a, done_a, ov_a;
  logic [19:0] bcd_a;

  logic        start_b;
  logic [15:0] bin_b;
  logic        ready_b, done_b, ov_b;
  logic [15:0] bcd_b;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .bin_i(bin_a),
    .ready_o(ready_a), .done_o(done_a), .bcd_o(bcd_a), .overflow_o(ov_a)
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .bin_i(bin_b),
    .ready_o(ready_b), .done_o(done_b), .bcd_o(bcd_b), .overflow_o(ov_b)
  );

  // Decimal digits of v, least significant digit in bits [3:0].
  function automatic logic [39:0] model_bcd(input longint unsigned v);
    logic [39:0] r;
    longint unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < 10; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Start one conversion on DUT a (sel=0) or b (sel=1); lat counts edges
  // after the accepting edge until done is seen (16 expected).
  task automatic run_conv(input bit sel, input logic [15:0] val,
                          output logic [19:0] bcd, output logic ov,
                          output int lat);
    int guard;
    guard = 0;
    while (!(sel ? ready_b : ready_a) && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (sel) begin start_b = 1'b1; bin_b = val; end
    else     begin start_a = 1'b1; bin_a = val; end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (sel ? done_b : done_a) break;
    end
    bcd = sel ? {4'h0, bcd_b} : bcd_a;
    ov  = sel ? ov_b : ov_a;
    $display("conv dut%0d bin=%0d bcd=%h ov=%0d lat=%0d", sel, val, bcd, ov, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 1'b0; bin_a = '0;
    start_b = 1'b0; bin_b = '0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_a); end
    checks++; if (bcd_a !== 20'h0) begin errors++; $display("FAIL reset_bcd got %h exp 00000", bcd_a); end
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_ov got %b exp 0", ov_a); end
    rst_n = 1'b1;
    $display("reset done");
  endtask

  task automatic test_zero();
    logic [19:0] bcd; logic ov; int lat;
    run_conv(1'b0, 16'd0, bcd, ov, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL zero_latency got %0d exp 16", lat); end
    checks++; if (bcd !== 20'h0) begin errors++; $display("FAIL zero_bcd got %h exp 00000", bcd); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL zero_ov got %b exp 0", ov); end
    @(posedge clk); #1;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL zero_ready_back got %b exp 1", ready_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL zero_done_single got %b exp 0", done_a); end
  endtask

  task automatic test_values5();
    logic [19:0] bcd; logic ov; int lat;
    run_conv(1'b0, 16'd65535, bcd, ov, lat);
    checks++; if (bcd !== 20'h65535 || ov !== 1'b0 || lat !== 16) begin
      errors++; $display("FAIL max_value got %h ov=%b lat=%0d exp 65535 ov=0 lat=16", bcd, ov, lat); end
    run_conv(1'b0, 16'd46368, bcd, ov, lat);
    checks++; if (bcd !== 20'h46368 || ov !== 1'b0) begin
      errors++; $display("FAIL fib24 got %h ov=%b exp 46368 ov=0", bcd, ov); end
    run_conv(1'b0, 16'd9, bcd, ov, lat);
    checks++; if (bcd !== 20'h00009) begin errors++; $display("FAIL nine got %h exp 00009", bcd); end
  endtask

  task automatic test_overflow4();
    logic [19:0] bcd; logic ov; int lat;
    run_conv(1'b1, 16'd9999, bcd, ov, lat);
    checks++; if (bcd[15:0] !== 16'h9999 || ov !== 1'b0) begin
      errors++; $display("FAIL d4_9999 got %h ov=%b exp 9999 ov=0", bcd[15:0], ov); end
    run_conv(1'b1, 16'd10000, bcd, ov, lat);
    checks++; if (bcd[15:0] !== 16'h0000 || ov !== 1'b1) begin
      errors++; $display("FAIL d4_10000 got %h ov=%b exp 0000 ov=1", bcd[15:0], ov); end
    run_conv(1'b1, 16'd12345, bcd, ov, lat);
    checks++; if (bcd[15:0] !== 16'h2345 || ov !== 1'b1) begin
      errors++; $display("FAIL d4_12345 got %h ov=%b exp 2345 ov=1", bcd[15:0], ov); end
    run_conv(1'b1, 16'd42, bcd, ov, lat);
    checks++; if (bcd[15:0] !== 16'h0042 || ov !== 1'b0) begin
      errors++; $display("FAIL d4_ov_clear got %h ov=%b exp 0042 ov=0", bcd[15:0], ov); end
  endtask

  task automatic test_ignore_start();
    int ndone, done_at, hold_bad, j;
    logic [19:0] got;
    logic [19:0] bcd; logic ov; int lat;
    ndone = 0; done_at = -1; got = '0;
    bin_a = 16'd1234; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done_a) begin ndone++; done_at = k; got = bcd_a; end
      if (k == 2) begin start_a = 1'b1; bin_a = 16'd777; end
      else if (k == 3) start_a = 1'b0;
      if (k >= 3 && k <= 8) bin_a = 16'($urandom);
    end
    $display("conv dut0 bin=1234 bcd=%h with ignored start", got);
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", ndone); end
    checks++; if (done_at !== 16) begin errors++; $display("FAIL ignore_done_at got %0d exp 16", done_at); end
    checks++; if (got !== 20'h01234) begin errors++; $display("FAIL ignore_result got %h exp 01234", got); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL ignore_ready got %b exp 1", ready_a); end
    // Second conversion: previous result must hold until the commit.
    hold_bad = 0; j = 0;
    bin_a = 16'd777; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    while (j < 40) begin
      @(posedge clk); #1;
      j++;
      if (done_a) break;
      if (bcd_a !== 20'h01234) hold_bad++;
    end
    bcd = bcd_a; ov = ov_a; lat = j;
    $display("conv dut0 bin=777 bcd=%h ov=%0d lat=%0d", bcd, ov, lat);
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL hold_prev got %0d bad cycles exp 0", hold_bad); end
    checks++; if (bcd !== 20'h00777 || lat !== 16) begin
      errors++; $display("FAIL second_result got %h lat=%0d exp 00777 lat=16", bcd, lat); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    logic [19:0] bcd; logic ov; int lat;
    bin_a = 16'd999; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("reset mid-shift");
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", ready_a); end
    checks++; if (bcd_a !== 20'h0 || ov_a !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got %h ov=%b exp 00000 ov=0", bcd_a, ov_a); end
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      if (done_a) ndone++;
      @(posedge clk); #1;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", ndone); end
    run_conv(1'b0, 16'd42, bcd, ov, lat);
    checks++; if (bcd !== 20'h00042 || ov !== 1'b0) begin
      errors++; $display("FAIL after_rst got %h ov=%b exp 00042 ov=0", bcd, ov); end
  endtask

  task automatic test_back_to_back();
    int unsigned fib [25];
    logic [39:0] exp_bcd;
    int acc, res, cyc, last_done, spacing_bad;
    logic was_ready;
    fib[0] = 0; fib[1] = 1;
    for (int i = 2; i < 25; i++) fib[i] = fib[i-1] + fib[i-2];
    acc = 0; res = 0; cyc = 0; last_done = -1; spacing_bad = 0;
    start_a = 1'b1; bin_a = 16'(fib[0]);
    was_ready = ready_a;
    while (res < 25 && cyc < 700) begin
      @(posedge clk); #1;
      cyc++;
      if (was_ready) acc++;
      if (done_a) begin
        exp_bcd = model_bcd(longint'(fib[res]));
        $display("b2b fib%0d bin=%0d bcd=%h", res, fib[res], bcd_a);
        checks++; if (bcd_a !== exp_bcd[19:0] || ov_a !== 1'b0) begin
          errors++; $display("FAIL b2b_fib%0d got %h ov=%b exp %h ov=0", res, bcd_a, ov_a, exp_bcd[19:0]); end
        if (last_done >= 0 && cyc - last_done != 18) spacing_bad++;
        last_done = cyc;
        res++;
      end
      if (acc >= 25) start_a = 1'b0;
      else bin_a = 16'(fib[acc]);
      was_ready = ready_a;
    end
    start_a = 1'b0;
    checks++; if (res !== 25) begin errors++; $display("FAIL b2b_results got %0d exp 25", res); end
    checks++; if (acc !== 25) begin errors++; $display("FAIL b2b_accepts got %0d exp 25", acc); end
    checks++; if (spacing_bad !== 0) begin errors++; $display("FAIL b2b_spacing got %0d bad gaps exp 0", spacing_bad); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values5();
    test_overflow4();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
